// File: rtl/branch_predictor.sv
// branch_predictor: BTB + 2-bit PHT (static/bimodal/gshare) with registered fetch prediction
module branch_predictor #(
  parameter int ADDR_WIDTH      = 26,
  parameter int BTB_ENTRIES     = 64,
  parameter int PHT_INDEX_WIDTH = 8,
  parameter int GHR_WIDTH       = 8,
  parameter int MODE            = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_fetch_valid,
  input  logic                  i_stall,
  input  logic [ADDR_WIDTH-1:0] i_fetch_pc,
  output logic                  o_predict_valid,
  output logic                  o_predict_taken,
  output logic [ADDR_WIDTH-1:0] o_predict_target,
  output logic [GHR_WIDTH-1:0]  o_predict_ghr,
  input  logic                  i_update_valid,
  input  logic [ADDR_WIDTH-1:0] i_update_pc,
  input  logic                  i_update_taken,
  input  logic [ADDR_WIDTH-1:0] i_update_target,
  input  logic [GHR_WIDTH-1:0]  i_update_ghr,
  input  logic                  i_update_mispredict,
  output logic [31:0]           o_mispredict_count
);
  localparam int BW = $clog2(BTB_ENTRIES);
  localparam int TW = ADDR_WIDTH - BW - 2;
  localparam int PD = 1 << PHT_INDEX_WIDTH;
  logic                  btb_valid  [BTB_ENTRIES];
  logic [TW-1:0]         btb_tag    [BTB_ENTRIES];
  logic [ADDR_WIDTH-1:0] btb_target [BTB_ENTRIES];
  logic [1:0]            pht        [PD];
  logic [GHR_WIDTH-1:0]  ghr;
  logic [BW-1:0]              f_bi, u_bi;
  logic [PHT_INDEX_WIDTH-1:0] f_pi, u_pi;
  logic                       f_hit, f_taken, lookup;
  logic [1:0]                 f_ctr, u_ctr, u_ctr_next;
  logic [ADDR_WIDTH-1:0]      f_target;
  logic                       unused_bits;
  function automatic logic [PHT_INDEX_WIDTH-1:0] pht_idx(input logic [ADDR_WIDTH-1:0] pc,
                                                         input logic [GHR_WIDTH-1:0] h);
    return (MODE == 2) ? pc[PHT_INDEX_WIDTH+1:2] ^ PHT_INDEX_WIDTH'(h) : pc[PHT_INDEX_WIDTH+1:2];
  endfunction
  assign unused_bits = ^i_update_pc[1:0];
  assign lookup      = i_fetch_valid && !i_stall;
  // lookup reads pre-update contents; update computes the saturated counter
  always_comb begin
    f_bi       = i_fetch_pc[BW+1:2];
    f_pi       = pht_idx(i_fetch_pc, ghr);
    f_ctr      = pht[f_pi];
    f_hit      = btb_valid[f_bi] && (btb_tag[f_bi] == i_fetch_pc[ADDR_WIDTH-1:BW+2]);
    f_taken    = (MODE != 0) && f_hit && f_ctr[1];
    f_target   = f_taken ? btb_target[f_bi] : i_fetch_pc + ADDR_WIDTH'(4);
    u_bi       = i_update_pc[BW+1:2];
    u_pi       = pht_idx(i_update_pc, i_update_ghr);
    u_ctr      = pht[u_pi];
    u_ctr_next = i_update_taken ? (&u_ctr ? u_ctr : u_ctr + 2'd1) : (|u_ctr ? u_ctr - 2'd1 : u_ctr);
  end
  // registered prediction, held while IF is stalled
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      o_predict_valid  <= 1'b0;
      o_predict_taken  <= 1'b0;
      o_predict_target <= '0;
      o_predict_ghr    <= '0;
    end else if (!i_stall) begin
      o_predict_valid  <= i_fetch_valid;
      o_predict_taken  <= f_taken;
      o_predict_target <= f_target;
      o_predict_ghr    <= ghr;
    end
  // global history: mispredict repair beats the speculative shift
  always_ff @(posedge clk or posedge rst)
    if (rst) ghr <= '0;
    else if (i_update_valid && i_update_mispredict) ghr <= GHR_WIDTH'({i_update_ghr, i_update_taken});
    else if (lookup && f_hit) ghr <= GHR_WIDTH'({ghr, f_taken});
  // mispredict counter, wraps
  always_ff @(posedge clk or posedge rst)
    if (rst) o_mispredict_count <= '0;
    else if (i_update_valid && i_update_mispredict) o_mispredict_count <= o_mispredict_count + 32'd1;
  // BTB allocates only on taken branches
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
      end
    end else if (i_update_valid && i_update_taken) begin
      btb_valid[u_bi]  <= 1'b1;
      btb_tag[u_bi]    <= i_update_pc[ADDR_WIDTH-1:BW+2];
      btb_target[u_bi] <= i_update_target;
    end
  // PHT trains in every mode, counters start weakly not-taken
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < PD; i++) pht[i] <= 2'b01;
    else if (i_update_valid) pht[u_pi] <= u_ctr_next;
endmodule
